// File: rtl/sram_uart_arbiter.sv
// Arbiter between the CPU fetch/data ports, two asynchronous SRAM banks and the UART.
// Bank2 serves instruction fetch whenever it is not claimed by a data access.
module sram_uart_arbiter #(
  parameter int                DATA_W         = 16,
  parameter int                ADDR_W         = 18,
  parameter int                PC_W           = 16,
  parameter logic [ADDR_W-1:0] SPLIT_ADDR     = 18'h08000,
  parameter logic [ADDR_W-1:0] UART_DATA_ADDR = 18'h0BF00,
  parameter logic [ADDR_W-1:0] UART_STAT_ADDR = 18'h0BF01,
  parameter int                WE_CYCLES      = 2,
  parameter logic [DATA_W-1:0] NOP_INST       = 16'h0800
) (
  input  logic              clk_50MHz,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_pause,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  inout  wire  [DATA_W-1:0] sram1_data,
  output logic [ADDR_W-1:0] sram1_addr,
  output logic              sram1_en,
  output logic              sram1_oe,
  output logic              sram1_we,
  inout  wire  [DATA_W-1:0] sram2_data,
  output logic [ADDR_W-1:0] sram2_addr,
  output logic              sram2_en,
  output logic              sram2_oe,
  output logic              sram2_we,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre,
  output logic              rdn,
  output logic              wrn,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    B1_RD  = 4'd1,
    B1_WR  = 4'd2,
    B2_RD  = 4'd3,
    B2_WR  = 4'd4,
    U_RD   = 4'd5,
    U_WR   = 4'd6,
    U_WAIT = 4'd7,
    DONE   = 4'd8
  } state_t;

  localparam int               CNT_W    = $clog2(WE_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_WE   = CNT_W'(WE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_URD  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              fetch_q;
  logic              sram1_drv;
  logic              sram2_drv;
  logic [DATA_W-1:0] sram1_dout;
  logic [DATA_W-1:0] sram2_dout;
  logic [ADDR_W-1:0] pc_ext;

  assign pc_ext     = {{(ADDR_W - PC_W){1'b0}}, pc};
  assign sram1_data = sram1_drv ? sram1_dout : {DATA_W{1'bz}};
  assign sram2_data = sram2_drv ? sram2_dout : {DATA_W{1'bz}};
  assign ram_pause  = mem_en & ~mem_ready;
  assign dbg_state  = state;

  // Valid/ready contract: a request (mem_en with op/addr/wdata stable) is taken only
  // in IDLE; completion is the single-cycle mem_ready pulse, and the requester must
  // drop mem_en in that cycle unless it wants the access repeated.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fetch_q    <= 1'b0;
      sram1_addr <= '0;
      sram1_en   <= 1'b1;
      sram1_oe   <= 1'b1;
      sram1_we   <= 1'b1;
      sram1_drv  <= 1'b0;
      sram1_dout <= '0;
      sram2_addr <= '0;
      sram2_en   <= 1'b1;
      sram2_oe   <= 1'b1;
      sram2_we   <= 1'b1;
      sram2_drv  <= 1'b0;
      sram2_dout <= '0;
      rdn        <= 1'b1;
      wrn        <= 1'b1;
      mem_ready  <= 1'b0;
      mem_rdata  <= '0;
      inst       <= NOP_INST;
      inst_valid <= 1'b0;
    end else begin
      // Baseline for the next cycle: bank1 and UART quiet, bank2 fetching pc.
      mem_ready  <= 1'b0;
      sram1_en   <= 1'b1;
      sram1_oe   <= 1'b1;
      sram1_we   <= 1'b1;
      sram1_drv  <= 1'b0;
      sram2_addr <= pc_ext;
      sram2_en   <= 1'b0;
      sram2_oe   <= 1'b0;
      sram2_we   <= 1'b1;
      sram2_drv  <= 1'b0;
      rdn        <= 1'b1;
      wrn        <= 1'b1;
      fetch_q    <= 1'b1;
      inst_valid <= fetch_q;
      if (fetch_q) begin
        inst <= sram2_data;
      end

      case (state)
        IDLE: begin
          if (mem_en) begin
            cnt <= '0;
            if (mem_addr == UART_STAT_ADDR) begin
              if (!mem_op) begin
                mem_rdata <= {{(DATA_W - 2){1'b0}}, data_ready, tbre & tsre};
              end
              mem_ready <= 1'b1;
              state     <= DONE;
            end else if (mem_addr == UART_DATA_ADDR) begin
              cnt <= CNT_ONE;
              if (mem_op) begin
                wrn        <= 1'b0;
                sram1_drv  <= 1'b1;
                sram1_dout <= {{(DATA_W - 8){1'b0}}, mem_wdata[7:0]};
                state      <= U_WR;
              end else begin
                rdn   <= 1'b0;
                state <= U_RD;
              end
            end else if (mem_addr < SPLIT_ADDR) begin
              // Bank2 claimed for data: the fetch pipeline holds its last instruction.
              sram2_addr <= mem_addr;
              fetch_q    <= 1'b0;
              inst_valid <= 1'b0;
              inst       <= inst;
              if (mem_op) begin
                sram2_oe   <= 1'b1;
                sram2_drv  <= 1'b1;
                sram2_dout <= mem_wdata;
                state      <= B2_WR;
              end else begin
                state <= B2_RD;
              end
            end else begin
              sram1_addr <= mem_addr;
              sram1_en   <= 1'b0;
              if (mem_op) begin
                sram1_drv  <= 1'b1;
                sram1_dout <= mem_wdata;
                state      <= B1_WR;
              end else begin
                sram1_oe <= 1'b0;
                state    <= B1_RD;
              end
            end
          end
        end

        B1_RD: begin
          mem_rdata <= sram1_data;
          mem_ready <= 1'b1;
          state     <= DONE;
        end

        B2_RD: begin
          mem_rdata <= sram2_data;
          mem_ready <= 1'b1;
          state     <= DONE;
        end

        // First write cycle is address setup with WE high; then WE_CYCLES of strobe.
        B1_WR: begin
          sram1_drv <= 1'b1;
          if (cnt == CNT_WE) begin
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            sram1_en <= 1'b0;
            sram1_we <= 1'b0;
            cnt      <= cnt + CNT_ONE;
          end
        end

        B2_WR: begin
          sram2_addr <= sram2_addr;
          sram2_oe   <= 1'b1;
          sram2_drv  <= 1'b1;
          fetch_q    <= 1'b0;
          if (cnt == CNT_WE) begin
            sram2_en  <= 1'b1;
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            sram2_en <= 1'b0;
            sram2_we <= 1'b0;
            cnt      <= cnt + CNT_ONE;
          end
        end

        U_RD: begin
          if (cnt == CNT_URD) begin
            mem_rdata <= {{(DATA_W - 8){1'b0}}, sram1_data[7:0]};
            mem_ready <= 1'b1;
            state     <= DONE;
          end else begin
            rdn <= 1'b0;
            cnt <= cnt + CNT_ONE;
          end
        end

        U_WR: begin
          sram1_drv <= 1'b1;
          if (cnt == CNT_WE) begin
            state <= U_WAIT;
          end else begin
            wrn <= 1'b0;
            cnt <= cnt + CNT_ONE;
          end
        end

        // Transmitter must drain completely before the write is reported done.
        U_WAIT: begin
          sram1_drv <= 1'b1;
          if (tbre && tsre) begin
            mem_ready <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_uart_arbiter.sv
// Bench for sram_uart_arbiter: SRAM/UART environment models, directed scenarios and
// randomized bank/status traffic checked against an address-map reference model.
module tb_sram_uart_arbiter;

  localparam int          WE_CYCLES = 2;
  localparam logic [17:0] SPLIT     = 18'h08000;
  localparam logic [17:0] UART_DATA = 18'h0BF00;
  localparam logic [17:0] UART_STAT = 18'h0BF01;
  localparam logic [15:0] NOP       = 16'h0800;
  localparam logic [3:0]  ST_IDLE   = 4'd0;
  localparam logic [3:0]  ST_U_WAIT = 4'd7;

  logic        clk_50MHz = 1'b0;
  logic        rst;
  logic        mem_en;
  logic        mem_op;
  logic [17:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        ram_pause;
  logic [15:0] pc;
  logic [15:0] inst;
  logic        inst_valid;
  wire  [15:0] sram1_data;
  logic [17:0] sram1_addr;
  logic        sram1_en, sram1_oe, sram1_we;
  wire  [15:0] sram2_data;
  logic [17:0] sram2_addr;
  logic        sram2_en, sram2_oe, sram2_we;
  logic        data_ready, tbre, tsre;
  logic        rdn, wrn;
  logic [3:0]  dbg_state;

  always #10 clk_50MHz = ~clk_50MHz;

  sram_uart_arbiter dut (
    .clk_50MHz (clk_50MHz),
    .rst       (rst),
    .mem_en    (mem_en),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .ram_pause (ram_pause),
    .pc        (pc),
    .inst      (inst),
    .inst_valid(inst_valid),
    .sram1_data(sram1_data),
    .sram1_addr(sram1_addr),
    .sram1_en  (sram1_en),
    .sram1_oe  (sram1_oe),
    .sram1_we  (sram1_we),
    .sram2_data(sram2_data),
    .sram2_addr(sram2_addr),
    .sram2_en  (sram2_en),
    .sram2_oe  (sram2_oe),
    .sram2_we  (sram2_we),
    .data_ready(data_ready),
    .tbre      (tbre),
    .tsre      (tsre),
    .rdn       (rdn),
    .wrn       (wrn),
    .dbg_state (dbg_state)
  );

  // Board environment: two asynchronous SRAMs and the UART receive register.
  logic [15:0] bank1 [0:262143];
  logic [15:0] bank2 [0:262143];
  logic [15:0] uart_rx;
  logic [7:0]  uart_tx;

  assign sram1_data = (!sram1_en && !sram1_oe) ? bank1[sram1_addr] :
                      (!rdn ? uart_rx : 16'hzzzz);
  assign sram2_data = (!sram2_en && !sram2_oe) ? bank2[sram2_addr] : 16'hzzzz;

  always @(posedge clk_50MHz) begin
    if (!sram1_en && !sram1_we) bank1[sram1_addr] <= sram1_data;
    if (!sram2_en && !sram2_we) bank2[sram2_addr] <= sram2_data;
    if (!wrn) uart_tx <= sram1_data[7:0];
  end

  function automatic logic [15:0] pattern(input logic [17:0] a);
    return a[15:0] ^ 16'h5A3C ^ {a[17:16], 14'b0};
  endfunction

  // Reference model: contents seen by the CPU at each address of the data map.
  logic [15:0] ref_mem [logic [17:0]];

  function automatic logic [15:0] model_read(input logic [17:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    if (a < SPLIT && a == 18'd3) return 16'h4A55;
    return pattern(a);
  endfunction

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    #1;
  endtask

  // Per-access observations gathered by the driver.
  int          lat, we1_low, we2_low, wrn_low, rdn_low;
  bit          pause_ok, en1_high, b2_valid_low, inst_held, timed_out;
  logic [15:0] held_inst, rd_obs;
  logic [17:0] sram2_addr_at1;
  logic [3:0]  state_at5;

  task automatic access(input logic op, input logic [17:0] a, input logic [15:0] wd,
                        input int tbre_low);
    mem_en = 1'b1; mem_op = op; mem_addr = a; mem_wdata = wd;
    #1;
    lat = 0; we1_low = 0; we2_low = 0; wrn_low = 0; rdn_low = 0;
    pause_ok = ram_pause; en1_high = 1'b1; b2_valid_low = 1'b1; inst_held = 1'b1;
    held_inst = inst; sram2_addr_at1 = '0; state_at5 = '0;
    do begin
      step();
      lat++;
      if (!sram1_we) we1_low++;
      if (!sram2_we) we2_low++;
      if (!wrn) wrn_low++;
      if (!rdn) rdn_low++;
      if (!sram1_en) en1_high = 1'b0;
      if (inst_valid) b2_valid_low = 1'b0;
      if (inst !== held_inst) inst_held = 1'b0;
      if (!mem_ready && !ram_pause) pause_ok = 1'b0;
      if (lat == 1) sram2_addr_at1 = sram2_addr;
      if (lat == 5) state_at5 = dbg_state;
      if (lat == tbre_low) begin tbre = 1'b1; tsre = 1'b1; end
    end while (!mem_ready && lat < 100);
    timed_out = !mem_ready;
    if (timed_out) check("access_timeout", {31'b0, mem_ready}, 32'd1);
    rd_obs = mem_rdata;
    mem_en = 1'b0;
    step();
  endtask

  logic [15:0] last_rd;

  initial begin
    rst = 1'b1; mem_en = 1'b0; mem_op = 1'b0; mem_addr = '0; mem_wdata = '0;
    pc = 16'd3; data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; uart_rx = 16'h0000;
    for (int a = 0; a < 262144; a++) begin
      bank1[a] <= pattern(18'(a));
      bank2[a] <= pattern(18'(a));
    end
    bank2[3] <= 16'h4A55;
    repeat (3) step();

    // Reset state
    check("rst_strobes", {sram1_en, sram1_oe, sram1_we, sram2_en, sram2_oe, sram2_we, rdn, wrn}, 8'hFF);
    check("rst_addrs", {sram1_addr, sram2_addr}, 36'h0);
    check("rst_ready_rdata", {mem_ready, mem_rdata}, 17'h0);
    check("rst_inst", {inst_valid, inst}, {1'b0, NOP});
    check("rst_state", dbg_state, ST_IDLE);

    // Fetch start-up after reset release
    rst = 1'b0;
    step();
    check("fetch0_inst", {inst_valid, inst}, {1'b0, NOP});
    step();
    check("fetch1_inst", {inst_valid, inst}, {1'b1, 16'h4A55});
    check("fetch1_addr", sram2_addr, 18'd3);

    pc = 16'd5;
    step(); step();
    check("fetch_pc5", {inst_valid, inst}, {1'b1, pattern(18'd5)});

    // Bank1 write then read back
    access(1'b1, 18'h0C000, 16'hBEEF, 0);
    ref_mem[18'h0C000] = 16'hBEEF;
    check("b1_wr_lat", lat, 1 + WE_CYCLES + 1);
    check("b1_wr_we_low", we1_low, WE_CYCLES);
    check("b1_wr_pause", pause_ok, 1);
    check("b1_wr_sram", bank1[18'h0C000], 16'hBEEF);
    check("b1_wr_rdata_hold", rd_obs, 16'h0000);
    access(1'b0, 18'h0C000, 16'h0000, 0);
    check("b1_rd_lat", lat, 2);
    check("b1_rd_data", rd_obs, 16'hBEEF);
    check("b1_rd_pause", pause_ok, 1);

    // Bank2 data read suspends fetch
    access(1'b0, 18'h00010, 16'h0000, 0);
    check("b2_rd_lat", lat, 2);
    check("b2_rd_data", rd_obs, model_read(18'h00010));
    check("b2_rd_addr", sram2_addr_at1, 18'h00010);
    check("b2_rd_valid_low", b2_valid_low, 1);
    check("b2_rd_inst_held", inst_held, 1);
    check("b2_fetch_resume", {inst_valid, inst}, {1'b1, pattern(18'd5)});

    // UART write with the transmitter busy for six cycles
    tbre = 1'b0;
    access(1'b1, UART_DATA, 16'h0041, 6);
    check("u_wr_wrn_low", wrn_low, WE_CYCLES);
    check("u_wr_waiting", state_at5, ST_U_WAIT);
    check("u_wr_lat", lat, 7);
    check("u_wr_en1_high", en1_high, 1);
    check("u_wr_byte", uart_tx, 8'h41);
    check("u_wr_rdata_hold", rd_obs, model_read(18'h00010));

    // Status read then UART data read
    data_ready = 1'b1; tbre = 1'b1; tsre = 1'b0;
    access(1'b0, UART_STAT, 16'h0000, 0);
    check("stat_lat", lat, 1);
    check("stat_data", rd_obs, 16'h0002);
    tsre = 1'b1; data_ready = 1'b0;
    uart_rx = 16'hFF5A;
    access(1'b0, UART_DATA, 16'h0000, 0);
    check("u_rd_lat", lat, 3);
    check("u_rd_rdn_low", rdn_low, 2);
    check("u_rd_data", rd_obs, 16'h005A);
    check("u_rd_en1_high", en1_high, 1);
    last_rd = 16'h005A;

    // Randomized bank and status traffic
    for (int n = 0; n < 30; n++) begin
      int          kind;
      int          exp_lat;
      logic [17:0] a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      logic        dr, tb, ts;
      kind = $urandom_range(0, 5);
      d    = 16'($urandom);
      case (kind)
        0, 1:    a = 18'h10000 + 18'($urandom_range(0, 7));
        2, 3:    a = 18'h00100 + 18'($urandom_range(0, 7));
        default: a = UART_STAT;
      endcase
      dr = 1'($urandom_range(0, 1));
      tb = 1'($urandom_range(0, 1));
      ts = 1'($urandom_range(0, 1));
      if (kind >= 4) begin data_ready = dr; tbre = tb; tsre = ts; end
      case (kind)
        0, 2: begin exp_rd = model_read(a); exp_lat = 2; last_rd = exp_rd; end
        1, 3: begin ref_mem[a] = d; exp_rd = last_rd; exp_lat = WE_CYCLES + 2; end
        4:    begin exp_rd = {14'b0, dr, tb & ts}; exp_lat = 1; last_rd = exp_rd; end
        default: begin exp_rd = last_rd; exp_lat = 1; end
      endcase
      access(kind[0] ? 1'b1 : 1'b0, a, d, 0);
      check($sformatf("rnd%0d_k%0d_lat", n, kind), lat, exp_lat);
      check($sformatf("rnd%0d_k%0d_rdata", n, kind), rd_obs, exp_rd);
      data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1;
    end

    // Reset during the write strobe of a bank1 write aborts it
    mem_en = 1'b1; mem_op = 1'b1; mem_addr = 18'h0D000; mem_wdata = 16'h1234;
    step();
    step();
    check("abort_we_active", sram1_we, 1'b0);
    rst = 1'b1; mem_en = 1'b0;
    step();
    check("abort_strobes", {sram1_en, sram1_oe, sram1_we, rdn, wrn}, 5'h1F);
    check("abort_no_ready", mem_ready, 1'b0);
    check("abort_state", dbg_state, ST_IDLE);
    check("abort_rdata", mem_rdata, 16'h0000);
    rst = 1'b0;
    step();
    check("abort_post_ready0", mem_ready, 1'b0);
    step();
    check("abort_post_ready1", mem_ready, 1'b0);
    access(1'b0, 18'h0C000, 16'h0000, 0);
    check("post_abort_rd_lat", lat, 2);
    check("post_abort_rd_data", rd_obs, model_read(18'h0C000));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
